mult_div_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers for the 5-stage MIPS pipeline. It lives in the Execute stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo on a single-cycle Start pulse. It asserts Busy for a fixed latency, which the hazard control consumes to stall later HI/LO-using instructions in Decode.

---
 rtl/mult_div_unit_if.sv | 28 ++
 rtl/mult_div_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit_if
//  Brief    : Execute-stage launch/result bundle for the multiply/divide unit.
//             The pipeline (master) launches operations; the unit (slave)
//             reports Busy and the architectural HI/LO registers.
//  Revision : 1.0 - initial release
// ============================================================================
interface mult_div_unit_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, Op, A, B,
    input  Busy, HI, LO
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, HI, LO
  );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Brief    : Fixed-latency multiply/divide unit with HI/LO registers for the
//             Execute stage. Operands are latched on launch; the result is
//             formed from the latched copies on the final busy edge.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic      Clk,
  input  wire logic      Reset,
  mult_div_unit_if.slave bus
);

  localparam logic [2:0] c_OP_MULT  = 3'd1;
  localparam logic [2:0] c_OP_MULTU = 3'd2;
  localparam logic [2:0] c_OP_DIV   = 3'd3;
  localparam logic [2:0] c_OP_DIVU  = 3'd4;
  localparam logic [2:0] c_OP_MTHI  = 3'd5;
  localparam logic [2:0] c_OP_MTLO  = 3'd6;

  localparam logic [4:0] c_MULT_LOAD = 5'(MULT_CYCLES);
  localparam logic [4:0] c_DIV_LOAD  = 5'(DIV_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        w_latch;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;

  // Products: sign- or zero-extend to 64 bits so a plain 64-bit multiply
  // yields the exact two's-complement result in both cases.
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Division runs on magnitudes and re-applies signs afterwards. This keeps
  // 0x80000000 / -1 well defined: the magnitude quotient 2^31 wraps back to
  // 0x80000000 with a zero remainder.
  logic        w_div_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_div_signed = (r_op == c_OP_DIV);
  assign w_a_mag = (w_div_signed && r_a[31]) ? (~r_a + 32'd1) : r_a;
  assign w_b_mag = (w_div_signed && r_b[31]) ? (~r_b + 32'd1) : r_b;
  assign w_q_mag = w_a_mag / w_b_mag;
  assign w_r_mag = w_a_mag % w_b_mag;
  assign w_quot  = (w_div_signed && (r_a[31] ^ r_b[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem   = (w_div_signed && r_a[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

  // Next-state, counter and HI/LO update selection.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (bus.Start) begin
          case (bus.Op)
            c_OP_MULT, c_OP_MULTU: begin
              w_latch     = 1'b1;
              w_cnt_nxt   = c_MULT_LOAD;
              w_state_nxt = S_BUSY;
            end
            c_OP_DIV, c_OP_DIVU: begin
              w_latch     = 1'b1;
              w_cnt_nxt   = c_DIV_LOAD;
              w_state_nxt = S_BUSY;
            end
            c_OP_MTHI: w_hi_nxt = bus.A;
            c_OP_MTLO: w_lo_nxt = bus.A;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        // A count of 0 cannot occur in BUSY; treating it as final keeps the
        // unit from wrapping into a 31-cycle stall if it ever did.
        if (r_cnt <= 5'd1) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 5'd0;
          case (r_op)
            c_OP_MULT:  {w_hi_nxt, w_lo_nxt} = w_prod_s;
            c_OP_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_u;
            c_OP_DIV, c_OP_DIVU: begin
              // Divide by zero leaves HI/LO untouched.
              if (r_b != 32'd0) begin
                w_hi_nxt = w_rem;
                w_lo_nxt = w_quot;
              end
            end
            default: ;
          endcase
        end else begin
          w_cnt_nxt = r_cnt - 5'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter, latched operands and HI/LO registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_op    <= 3'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      if (w_latch) begin
        r_op <= bus.Op;
        r_a  <= bus.A;
        r_b  <= bus.B;
      end
    end
  end

  assign bus.Busy = (r_state == S_BUSY);
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule
`default_nettype wire
